// File: rtl/fpu_issue_sequencer.sv
// Round-robin issue sequencer for the shared FP add/multiply datapath.
// It accepts one request, holds the FP unit inputs for LATENCY cycles, and then holds the response until it is taken.
module fpu_issue_sequencer #(
    parameter int unsigned LATENCY = 3,
    parameter logic [5:0]  OP_FADD = 6'd23,
    parameter logic [5:0]  OP_FMUL = 6'd24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] fu_a,
    output logic [31:0] fu_b,
    output logic [5:0]  fu_opcode,
    input  logic [31:0] fu_add_result,
    input  logic [31:0] fu_mul_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        id_q, id_d, err_q, err_d;

    logic        grant0, grant1, accept, acc_id, acc_fp;
    logic [5:0]  acc_op;
    logic [31:0] acc_a, acc_b;

    // ptr_q names the port that wins when both ports request in the same cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (req0_valid && (!req1_valid || !ptr_q)) grant0 = 1'b1;
            else if (req1_valid)                      grant1 = 1'b1;
        end
    end

    assign accept = grant0 | grant1;
    assign acc_id = grant1;
    assign acc_op = grant1 ? req1_opcode : req0_opcode;
    assign acc_a  = grant1 ? req1_a : req0_a;
    assign acc_b  = grant1 ? req1_b : req0_b;
    assign acc_fp = (acc_op == OP_FADD) || (acc_op == OP_FMUL);

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        id_d     = id_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d = ~acc_id;
                    id_d  = acc_id;
                    if (acc_fp) begin
                        op_d    = acc_op;
                        a_d     = acc_a;
                        b_d     = acc_b;
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = EXEC;
                    end else begin
                        // An unsupported opcode never reaches the FP unit, so the fu_* outputs keep their last values.
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    result_d = (op_q == OP_FADD) ? fu_add_result : fu_mul_result;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values together.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            id_q     <= id_d;
            err_q    <= err_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign fu_a       = a_q;
    assign fu_b       = b_q;
    assign fu_opcode  = op_q;
    assign rsp_valid  = (state_q == DONE);
    assign rsp_result = result_q;
    assign rsp_id     = id_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != IDLE);

endmodule
